// File: rtl/conv_pkg.sv
// conv_pkg: shared state type, accumulator sizing and saturation helper for conv_pipe
package conv_pkg;
  typedef enum logic {LOAD, COMPUTE} state_t;
  function automatic int acc_width(input int dx, input int df, input int fs);
    return dx + df + $clog2(fs);
  endfunction
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] val, input int width);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return val > hi ? hi : val < lo ? lo : val;
  endfunction
endpackage

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: product register plus load/add accumulator, frozen as a whole by stall
module conv_mac_pipe #(
  parameter int DX = 8,
  parameter int DF = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    in_valid,
  input  logic                    first,
  input  logic                    last,
  input  logic signed [DX-1:0]    x,
  input  logic signed [DF-1:0]    f,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid
);
  logic signed [DX+DF-1:0] prod;
  logic v_p, first_p, last_p;
  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
      v_p <= 1'b0;
      first_p <= 1'b0;
      last_p <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
    end else if (!stall) begin
      prod <= x * f;
      v_p <= in_valid;
      first_p <= first;
      last_p <= last;
      if (v_p) result <= first_p ? ACC_W'(prod) : result + ACC_W'(prod);
      result_valid <= v_p && last_p;
    end
  end
endmodule

// File: rtl/conv_pipe.sv
// conv_pipe: pipelined 1-D valid convolution of streamed x and f vectors.
// Define CONV_SAT_EN to clamp results to OUT_WIDTH instead of wrapping.
module conv_pipe
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE = 8,
  parameter int F_SIZE = 4,
  parameter int OUT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid_x,
  output logic                           s_ready_x,
  input  logic signed [DATA_WIDTH_X-1:0] s_data_in_x,
  input  logic                           s_valid_f,
  output logic                           s_ready_f,
  input  logic signed [DATA_WIDTH_F-1:0] s_data_in_f,
  output logic                           m_valid_y,
  input  logic                           m_ready_y,
  output logic signed [OUT_WIDTH-1:0]    m_data_out_y
);
  localparam int ACC_W = acc_width(DATA_WIDTH_X, DATA_WIDTH_F, F_SIZE);
  localparam int AW = $clog2(X_SIZE);
  localparam int CW = $clog2(X_SIZE + 1);
  localparam int KW = $clog2(F_SIZE);
  localparam int FW = $clog2(F_SIZE + 1);
  state_t state, state_n;
  logic [CW-1:0] cx;
  logic [FW-1:0] cf;
  logic [AW-1:0] j, oc;
  logic [KW-1:0] k;
  logic issued, issue_v, issue, v1, first1, last1, res_valid, stall, xfer, fin;
  logic acc_x, acc_f, full_x, full_f;
  logic signed [DATA_WIDTH_X-1:0] xmem [X_SIZE];
  logic signed [DATA_WIDTH_F-1:0] fmem [F_SIZE];
  logic signed [DATA_WIDTH_X-1:0] rx;
  logic signed [DATA_WIDTH_F-1:0] rf;
  logic signed [ACC_W-1:0] res;
  logic signed [OUT_WIDTH-1:0] y_n;
  // a full, undrained holding register freezes every pipeline stage
  assign stall = m_valid_y && !m_ready_y;
  assign xfer = res_valid && !stall;
  assign fin = xfer && oc == AW'(X_SIZE - F_SIZE);
  assign issue_v = state == COMPUTE && !issued;
  assign issue = issue_v && !stall;
  assign acc_x = s_valid_x && s_ready_x;
  assign acc_f = s_valid_f && s_ready_f;
  assign full_x = cx == CW'(X_SIZE) || (acc_x && cx == CW'(X_SIZE - 1));
  assign full_f = cf == FW'(F_SIZE) || (acc_f && cf == FW'(F_SIZE - 1));
  always_ff @(posedge clk) state <= reset ? LOAD : state_n;
  always_comb state_n = state == LOAD ? (full_x && full_f ? COMPUTE : LOAD) : (fin ? LOAD : COMPUTE);
  always_comb begin
    s_ready_x = state == LOAD && cx < CW'(X_SIZE);
    s_ready_f = state == LOAD && cf < FW'(F_SIZE);
  end
  always_ff @(posedge clk) begin
    if (acc_x) xmem[cx[AW-1:0]] <= s_data_in_x;
    if (acc_f) fmem[cf[KW-1:0]] <= s_data_in_f;
    if (!stall) begin
      rx <= xmem[j + AW'(k)];
      rf <= fmem[k];
    end
  end
  always_ff @(posedge clk) begin
    if (reset || fin) begin
      cx <= '0;
      cf <= '0;
      j <= '0;
      k <= '0;
      issued <= 1'b0;
      oc <= '0;
    end else begin
      if (acc_x) cx <= cx + 1'b1;
      if (acc_f) cf <= cf + 1'b1;
      if (xfer) oc <= oc + 1'b1;
      if (issue) begin
        k <= k == KW'(F_SIZE - 1) ? '0 : k + 1'b1;
        if (k == KW'(F_SIZE - 1)) begin
          j <= j == AW'(X_SIZE - F_SIZE) ? '0 : j + 1'b1;
          issued <= j == AW'(X_SIZE - F_SIZE);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      first1 <= 1'b0;
      last1 <= 1'b0;
    end else if (!stall) begin
      v1 <= issue_v;
      first1 <= k == '0;
      last1 <= k == KW'(F_SIZE - 1);
    end
  end
  conv_mac_pipe #(.DX(DATA_WIDTH_X), .DF(DATA_WIDTH_F), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .in_valid(v1),
    .first(first1),
    .last(last1),
    .x(rx),
    .f(rf),
    .result(res),
    .result_valid(res_valid)
  );
`ifdef CONV_SAT_EN
  assign y_n = OUT_WIDTH'(sat_to(64'(res), OUT_WIDTH));
`else
  assign y_n = OUT_WIDTH'(res);
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_y <= 1'b0;
      m_data_out_y <= '0;
    end else begin
      if (xfer) m_data_out_y <= y_n;
      m_valid_y <= xfer || stall;
    end
  end
endmodule

// File: tb/tb_conv_pipe.sv
// tb_conv_pipe: scoreboard bench for conv_pipe with directed vectors
module tb_conv_pipe;
  logic clk = 0, reset = 1;
  logic s_valid_x = 0, s_valid_f = 0, m_ready_y = 1;
  logic s_ready_x, s_ready_f, m_valid_y;
  logic signed [7:0] s_data_in_x = 0, s_data_in_f = 0;
  logic signed [15:0] m_data_out_y;
  conv_pipe dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x), .s_data_in_x(s_data_in_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f), .s_data_in_f(s_data_in_f),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y), .m_data_out_y(m_data_out_y)
  );
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0, last_acc = 0, n_acc = 0;
  int sb[$];
  int times[$];
  logic pv = 0, pr = 0;
  logic signed [15:0] pd = 0;
  logic signed [7:0] xa[8], fa[4];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      pv = 0;
      pr = 0;
    end else begin
      if (m_valid_y && (!pv || pr)) times.push_back(cyc);
      if (pv && !pr) begin
        chk("hold_valid", int'(m_valid_y), 1);
        chk("hold_data", int'(m_data_out_y), int'(pd));
      end
      if (m_valid_y && m_ready_y) begin
        n_acc++;
        if (sb.size() == 0) chk("unexpected_output", int'(m_data_out_y), 99999);
        else chk("y_value", int'(m_data_out_y), sb.pop_front());
      end
      pv = m_valid_y;
      pr = m_ready_y;
      pd = m_data_out_y;
    end
  end
  task automatic send_x(input logic signed [7:0] v[8]);
    for (int i = 0; i < 8; i++) begin
      int n = 0;
      s_valid_x = 1;
      s_data_in_x = v[i];
      while (!s_ready_x && n < 200) begin @(posedge clk); #1; n++; end
      if (n == 200) chk("x_ready_timeout", n, 0);
      @(posedge clk); #1;
      last_acc = cyc;
    end
    s_valid_x = 0;
  endtask
  task automatic send_f(input logic signed [7:0] v[4]);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      s_valid_f = 1;
      s_data_in_f = v[i];
      while (!s_ready_f && n < 200) begin @(posedge clk); #1; n++; end
      if (n == 200) chk("f_ready_timeout", n, 0);
      @(posedge clk); #1;
      last_acc = cyc;
    end
    s_valid_f = 0;
  endtask
  task automatic push5(input int a, input int b, input int c, input int d, input int e);
    sb.push_back(a); sb.push_back(b); sb.push_back(c); sb.push_back(d); sb.push_back(e);
  endtask
  task automatic wait_done();
    int n = 0;
    while (sb.size() > 0 && n < 400) begin @(posedge clk); n++; end
    chk("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic check_timing(input int gap1);
    if (times.size() != 5) chk("n_outputs", times.size(), 5);
    else begin
      chk("latency", times[0] - last_acc, 7);
      chk("gap1", times[1] - times[0], gap1);
      for (int i = 2; i < 5; i++) chk("gap", times[i] - times[i-1], 4);
    end
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_x", int'(s_ready_x), 1);
    chk("rst_ready_f", int'(s_ready_f), 1);
    chk("rst_valid", int'(m_valid_y), 0);
    chk("rst_data", int'(m_data_out_y), 0);
    reset = 0;
    xa = '{1, 2, 3, 4, 5, 6, 7, 8};
    fa = '{1, 1, 1, 1};
    times.delete();
    push5(10, 14, 18, 22, 26);
    fork send_x(xa); send_f(fa); join
    wait_done();
    check_timing(4);
    m_ready_y = 0;
    times.delete();
    push5(10, 14, 18, 22, 26);
    fork send_x(xa); send_f(fa); join
    n = 0;
    while (!m_valid_y && n < 100) begin @(posedge clk); #1; n++; end
    chk("first_valid_timeout", int'(m_valid_y), 1);
    repeat (10) @(posedge clk);
    #1;
    m_ready_y = 1;
    wait_done();
    check_timing(14);
    xa = '{127, 127, 127, 127, 127, 127, 127, 127};
    fa = '{127, 127, 127, 127};
    times.delete();
`ifdef CONV_SAT_EN
    push5(32767, 32767, 32767, 32767, 32767);
`else
    push5(-1020, -1020, -1020, -1020, -1020);
`endif
    fork
      send_x(xa);
      begin repeat (4) @(posedge clk); #1; send_f(fa); end
    join
    wait_done();
    check_timing(4);
    xa = '{-128, -128, -128, -128, -128, -128, -128, -128};
    times.delete();
`ifdef CONV_SAT_EN
    push5(-32768, -32768, -32768, -32768, -32768);
`else
    push5(512, 512, 512, 512, 512);
`endif
    fork send_x(xa); send_f(fa); join
    wait_done();
    check_timing(4);
    xa = '{1, 2, 3, 4, 5, 6, 7, 8};
    fa = '{1, 1, 1, 1};
    times.delete();
    n_acc = 0;
    push5(10, 14, 18, 22, 26);
    fork send_x(xa); send_f(fa); join
    n = 0;
    while (n_acc < 4 && n < 200) begin @(posedge clk); #1; n++; end
    chk("four_accepted", n_acc, 4);
    m_ready_y = 0;
    fa = '{1, -1, 2, 0};
    push5(5, 7, 9, 11, 13);
    fork send_x(xa); send_f(fa); join
    chk("held_valid_after_load", int'(m_valid_y), 1);
    chk("held_data_after_load", int'(m_data_out_y), 26);
    repeat (10) @(posedge clk);
    #1;
    m_ready_y = 1;
    wait_done();
    chk("batch_outputs", times.size(), 10);
    fa = '{1, 1, 1, 1};
    fork send_x(xa); send_f(fa); join
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    chk("midrst_valid", int'(m_valid_y), 0);
    chk("midrst_ready_x", int'(s_ready_x), 1);
    chk("midrst_ready_f", int'(s_ready_f), 1);
    reset = 0;
    xa = '{8, 7, 6, 5, 4, 3, 2, 1};
    times.delete();
    push5(26, 22, 18, 14, 10);
    fork send_x(xa); send_f(fa); join
    wait_done();
    check_timing(4);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_pipe.md
# conv_pipe

Parametrised, pipelined successor to the single-MAC 1-D convolution engine. It loads an X vector and an F vector over two independent AXI-stream-style slave ports, then computes all X_SIZE−F_SIZE+1 valid outputs through a registered multiply/accumulate pipeline. Results leave through an output holding register on a master port, and compile-time saturation is optional. It sits between the two input streams and the downstream consumer as a drop-in for the existing convolution slot.

## Interface
- DATA_WIDTH_X, 8: signed x sample width
- DATA_WIDTH_F, 8: signed f coefficient width
- X_SIZE, 8: x vector length (≥ F_SIZE, ≥ 2)
- F_SIZE, 4: filter length (≥ 2)
- OUT_WIDTH, 16: signed width of m_data_out_y (≤ internal accumulator width)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- s_valid_x  in  1  x word valid
- s_ready_x  out  1  x port can accept
- s_data_in_x  in  DATA_WIDTH_X  signed x word
- s_valid_f  in  1  f word valid
- s_ready_f  out  1  f port can accept
- s_data_in_f  in  DATA_WIDTH_F  signed f word
- m_valid_y  out  1  output word valid
- m_ready_y  in  1  consumer accepts
- m_data_out_y  out  OUT_WIDTH  signed result

## Operation
- Internal accumulator width ACC_W = DATA_WIDTH_X+DATA_WIDTH_F+$clog2(F_SIZE). Products are sign-extended to ACC_W, and no overflow is possible internally.
- States: LOAD, COMPUTE.
- LOAD:
  - The x and f ports fill independently, in order, at addresses 0.. (a word transfers when valid&&ready).
  - s_ready_x is high while the x count < X_SIZE. s_ready_f is high while the f count < F_SIZE.
  - When both memories are full, the block goes to COMPUTE and both readies are low.
- COMPUTE:
  - y[j] = Σ_{k=0}^{F_SIZE−1} x[j+k]·f[k], for j = 0..X_SIZE−F_SIZE.
  - One (j,k) address pair issues per cycle, continuously across output boundaries.
  - Pipeline stages: synchronous memory read, product register, accumulator.
  - The accumulator loads the product (rather than adding it) for k=0.
- Output holding register: the completed accumulator value transfers into it when the register is empty or is being drained in the same cycle.
  - If the register is full and not draining, the whole pipeline freezes: address issue, product register and accumulator all hold. No result is lost or duplicated.
- When the last output transfers into the holding register:
  - Both memory counters clear and the state returns to LOAD.
  - The next vectors may load while the last y is still waiting.
  - m_valid_y stays high until that y is accepted.
- m_data_out_y and m_valid_y hold steady while m_valid_y && !m_ready_y.
- Reset mid-operation: the pipeline flushes, counters clear, the state goes to LOAD, and the held output is discarded. Reset values apply on the next edge.

## Timing
- Reset values:
  - s_ready_x=1, s_ready_f=1 (LOAD, counts 0)
  - m_valid_y=0, m_data_out_y=0
  - state LOAD, accumulator 0
- COMPUTE is entered on the edge after the last input word (of either port) is accepted.
- First-output latency: m_valid_y rises exactly F_SIZE+3 cycles after the edge that accepted the final input word.
- Throughput with m_ready_y held high: one y every F_SIZE cycles, with no bubbles between outputs.
- Backpressure of N cycles on a full holding register delays every later output by exactly N cycles.
- s_ready_x and s_ready_f rise on the edge the last y enters the holding register, and stay low for the whole of COMPUTE.
- If a port's last accept and the other port's last accept fall on the same edge, the latency rule above still applies.

## Configuration
- CONV_SAT_EN defined:
  - The accumulator value is clamped to the signed OUT_WIDTH range [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] on transfer to the holding register.
  - Adds one compare stage, combinational before the holding register; latency is unchanged.
- CONV_SAT_EN undefined: the low OUT_WIDTH bits are taken (two's-complement wrap).

## Structure
- Package conv_pkg:
  - state enum {LOAD, COMPUTE}
  - function acc_width(dx, df, fs)
  - saturation function sat_to(val, width), used only under CONV_SAT_EN
- Sub-module conv_mac_pipe:
  - Contains the product register, accumulator with load/add select, and stall enable.
  - Inputs: two memory read data words, first-term flag, last-term flag, stall.
  - Outputs: result and result-valid.
- The top level holds the memories (existing memory module), load counters, address generator/FSM and the output holding register.

## Test plan
- Default parameters, x=1..8, f=1,1,1,1, m_ready_y=1 → y=10,14,18,22,26; first m_valid_y F_SIZE+3=7 cycles after the last accept; outputs 4 cycles apart.
- Same stimulus, m_ready_y low for 10 cycles after the first y → y[0] held stable; no loss or duplication; remaining outputs shifted exactly 10 cycles.
- x all 127, f all 127 (sum 64516), OUT_WIDTH=16 → with CONV_SAT_EN: 32767; without: −1020.
- x all −128, f all 127 (sum −65024) → with CONV_SAT_EN: −32768; without: 512.
- Drive the second x/f vector pair while the final y is held (m_ready_y=0) → loading completes; the final y stays valid and correct; the second batch's results follow.
- Assert reset during COMPUTE → on the next cycle m_valid_y=0, s_ready_x=s_ready_f=1; a fresh load then yields correct results.
